fft_controller: RTL and testbench

- Sequences one shared combinational radix-2 butterfly_block through every stage of an in-place, decimation-in-frequency FFT of 2^N_LOG2 points.
- Generates the following:
  - sample-RAM read addresses;
  - twiddle-ROM address;
  - delayed write-back addresses and write enable.
- Sits between the top-level FFT wrapper (start/done handshake) and the sample RAM / twiddle ROM / butterfly datapath.
- The sample RAM has two synchronous read ports (1-cycle read latency) and two write ports.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_addr_gen.sv | 54 +++++
 rtl/fft_controller.sv | 156 +++++++++++++++
 tb/tb_fft_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the in-place radix-2 DIF FFT controller slice.
//   N_LOG2_DEF : default log2 of the FFT size
//   N, HALF_N  : FFT size and butterflies per stage for the default size
//   ADDR_W     : sample-RAM address width
//   TW_W       : twiddle-ROM address width (ROM holds N/2 entries)
//   fft_ctrl_state_t : controller state encoding
//   stage_width()    : width of a stage index (at least one bit)
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int N_LOG2_DEF = 3;
  localparam int N          = 1 << N_LOG2_DEF;
  localparam int HALF_N     = N / 2;
  localparam int ADDR_W     = N_LOG2_DEF;
  localparam int TW_W       = N_LOG2_DEF - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fft_ctrl_state_t;

  // Stage counter width: enough bits to hold 0..nLog2-1, never zero.
  function automatic int stage_width(input int nLog2);
    return (nLog2 < 2) ? 1 : $clog2(nLog2);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_addr_gen
// Purely combinational address decode for one DIF butterfly.
// For butterfly b in stage s, with span = N >> (s+1):
//   rd_addr_a = (b div span) * 2*span + (b mod span)
//   rd_addr_b = rd_addr_a + span
//   tw_addr   = (b mod span) << s, truncated
// Ports:
//   stage_i     : stage index s
//   bfly_i      : butterfly index b within the stage (0..N/2-1)
//   rd_addr_a_o : upper-leg sample address
//   rd_addr_b_o : lower-leg sample address
//   tw_addr_o   : twiddle-ROM address
// -----------------------------------------------------------------------------
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic [stage_width(N_LOG2)-1:0] stage_i,
  input  logic [N_LOG2-2:0]              bfly_i,
  output logic [N_LOG2-1:0]              rd_addr_a_o,
  output logic [N_LOG2-1:0]              rd_addr_b_o,
  output logic [N_LOG2-2:0]              tw_addr_o
);

  localparam int AW  = N_LOG2;
  localparam int TWW = N_LOG2 - 1;
  localparam int SW  = stage_width(N_LOG2);
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [SW-1:0] shAmt;
  logic [AW-1:0] spanV;
  logic [AW-1:0] maskV;
  logic [AW-1:0] bflyExt;
  logic [AW-1:0] lowV;
  logic [AW-1:0] baseA;

  // span is a power of two, so div/mod reduce to a mask split of b. The upper
  // leg address is b with a zero bit inserted at the span position, i.e. the
  // high part of b shifted up one place and the low part left in place.
  always_comb begin
    shAmt       = SW'(N_LOG2 - 1) - stage_i;
    spanV       = ONE << shAmt;
    maskV       = spanV - ONE;
    bflyExt     = {1'b0, bfly_i};
    lowV        = bflyExt & maskV;
    baseA       = ((bflyExt & ~maskV) << 1) | lowV;
    rd_addr_a_o = baseA;
    rd_addr_b_o = baseA | spanV;
    tw_addr_o   = TWW'(lowV << stage_i);
  end

endmodule

// File: rtl/fft_controller.sv
// -----------------------------------------------------------------------------
// fft_controller
// Sequences one shared combinational radix-2 butterfly through every stage of
// an in-place decimation-in-frequency FFT of 2^N_LOG2 points. Output order is
// bit-reversed; reordering happens elsewhere.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : request a full FFT, sampled only in IDLE
//   stall      : memory-arbitration hold, freezes issue of new reads
//   busy       : high while running stages (RUN and DRAIN)
//   done       : one-cycle pulse after the final write has retired
//   stage      : current stage index
//   rd_en      : read request to both RAM read ports
//   rd_addr_a/b: upper/lower-leg read addresses
//   tw_addr    : twiddle-ROM address, presented with the read
//   wr_en      : write-back strobe for both write ports
//   wr_addr_a/b: write addresses for butterfly outputs 1 and 2
// -----------------------------------------------------------------------------
module fft_controller
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stall,
  output logic                           busy,
  output logic                           done,
  output logic [stage_width(N_LOG2)-1:0] stage,
  output logic                           rd_en,
  output logic [N_LOG2-1:0]              rd_addr_a,
  output logic [N_LOG2-1:0]              rd_addr_b,
  output logic [N_LOG2-2:0]              tw_addr,
  output logic                           wr_en,
  output logic [N_LOG2-1:0]              wr_addr_a,
  output logic [N_LOG2-1:0]              wr_addr_b
);

  localparam int AW = N_LOG2;
  localparam int BW = N_LOG2 - 1;
  localparam int SW = stage_width(N_LOG2);
  localparam logic [BW-1:0] LAST_BFLY  = {BW{1'b1}};
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);

  fft_ctrl_state_t state_q;
  logic [SW-1:0]   stage_q;
  logic [BW-1:0]   bfly_q;
  logic            busy_q;
  logic            done_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_a_q;
  logic [AW-1:0]   wr_addr_b_q;

  logic            runActive;
  logic [AW-1:0]   genAddrA;
  logic [AW-1:0]   genAddrB;
  logic [BW-1:0]   genTw;

  fft_addr_gen #(
    .N_LOG2(N_LOG2)
  ) u_addr_gen (
    .stage_i    (stage_q),
    .bfly_i     (bfly_q),
    .rd_addr_a_o(genAddrA),
    .rd_addr_b_o(genAddrB),
    .tw_addr_o  (genTw)
  );

  // Addresses are only driven in RUN so every output reads zero in reset and
  // while idle. They stay valid through a stall so the held pair is visible.
  // rd_en must drop in the same cycle stall rises, so it is a direct decode of
  // the state register and the stall input.
  always_comb begin
    runActive = (state_q == RUN);
    rd_en     = runActive && !stall;
    rd_addr_a = runActive ? genAddrA : '0;
    rd_addr_b = runActive ? genAddrB : '0;
    tw_addr   = runActive ? genTw    : '0;
  end

  // Control FSM. bfly wraps to zero naturally after the last issue of a stage;
  // DRAIN adds one idle read slot so the last write of a stage lands before
  // the first read of the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            stage_q <= '0;
            bfly_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            bfly_q <= bfly_q + 1'b1;
            if (bfly_q == LAST_BFLY) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          bfly_q <= '0;
          if (stage_q != LAST_STAGE) begin
            stage_q <= stage_q + 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          stage_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back trails the read by one cycle, matching the RAM read latency
  // plus the combinational butterfly. It ignores stall so an in-flight read
  // always retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
    end else begin
      wr_en_q     <= rd_en;
      wr_addr_a_q <= rd_addr_a;
      wr_addr_b_q <= rd_addr_b;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign wr_en     = wr_en_q;
  assign wr_addr_a = wr_addr_a_q;
  assign wr_addr_b = wr_addr_b_q;

endmodule

// File: tb/tb_fft_controller.sv
// -----------------------------------------------------------------------------
// tb_fft_controller
// Scoreboard bench for fft_controller (N_LOG2=3) plus a standalone
// fft_addr_gen instance at N_LOG2=4. Stimulus pushes expected reads, writes
// and done timing into queues; the monitor pops them as the DUT presents
// rd_en, wr_en and done.
// -----------------------------------------------------------------------------
module tb_fft_controller;

  localparam int NL = 3;

  typedef struct {
    int stg;
    int a;
    int b;
    int tw;
  } rdExp_t;

  typedef struct {
    int a;
    int b;
  } wrExp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic [1:0] stage;
  logic       rd_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_addr;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;

  logic [1:0] agStage;
  logic [2:0] agBfly;
  logic [3:0] agA;
  logic [3:0] agB;
  logic [2:0] agTw;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int busyCnt = 0;
  int wrCount = 0;

  rdExp_t expRd[$];
  wrExp_t expWr[$];
  int     expDone[$];
  int     expBusy[$];

  // Hand-computed N=8 schedule: stage 0, stage 1, stage 2, four butterflies each.
  int handA[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int handB[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int handTw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

  always #5 clk = ~clk;

  fft_controller #(
    .N_LOG2(NL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  fft_addr_gen #(
    .N_LOG2(4)
  ) agen (
    .stage_i    (agStage),
    .bfly_i     (agBfly),
    .rd_addr_a_o(agA),
    .rd_addr_b_o(agB),
    .tw_addr_o  (agTw)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    rdExp_t re;
    wrExp_t we;
    cyc++;
    if (busy === 1'b1) busyCnt++;
    if (stall === 1'b1 && rst === 1'b0) begin
      checkOutput("stallRdEn", rd_en, 0);
      if (expRd.size() > 0) begin
        checkOutput("stallHoldA", rd_addr_a, expRd[0].a);
        checkOutput("stallHoldB", rd_addr_b, expRd[0].b);
      end
    end
    if (rd_en === 1'b1) begin
      if (expRd.size() == 0) begin
        checkOutput("unexpectedRead", rd_en, 0);
      end else begin
        re = expRd.pop_front();
        checkOutput("rdStage", stage, re.stg);
        checkOutput("rdAddrA", rd_addr_a, re.a);
        checkOutput("rdAddrB", rd_addr_b, re.b);
        checkOutput("rdTw", tw_addr, re.tw);
      end
    end
    if (wr_en === 1'b1) begin
      wrCount++;
      if (expWr.size() == 0) begin
        checkOutput("unexpectedWrite", wr_en, 0);
      end else begin
        we = expWr.pop_front();
        checkOutput("wrAddrA", wr_addr_a, we.a);
        checkOutput("wrAddrB", wr_addr_b, we.b);
      end
    end
    if (done === 1'b1) begin
      if (expDone.size() == 0) begin
        checkOutput("unexpectedDone", done, 0);
      end else begin
        checkOutput("doneCycle", cyc, expDone.pop_front());
        checkOutput("busyAtDone", busy, 0);
        checkOutput("busyLength", busyCnt, expBusy.pop_front());
        busyCnt = 0;
      end
    end
  end

  // One FFT run. Cycle k counts clock periods after the edge that samples
  // start; stall covers cycles stallAt..stallAt+stallLen-1, start is re-pulsed
  // in cycles pulseA/pulseB, and resetAt (if nonzero) aborts in that cycle.
  task automatic applyStimulus(input int stallAt, input int stallLen,
                               input int pulseA, input int pulseB, input int resetAt);
    int     c0;
    rdExp_t re;
    wrExp_t we;
    for (int i = 0; i < 12; i++) begin
      re.stg = i / 4;
      re.a   = handA[i];
      re.b   = handB[i];
      re.tw  = handTw[i];
      expRd.push_back(re);
      we.a = handA[i];
      we.b = handB[i];
      expWr.push_back(we);
    end
    busyCnt = 0;
    wrCount = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    c0    = cyc;
    if (resetAt == 0) begin
      expDone.push_back(c0 + 17 + stallLen);
      expBusy.push_back(15 + stallLen);
    end
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      start = (k == pulseA) || (k == pulseB);
      stall = (stallLen > 0) && (k >= stallAt) && (k < stallAt + stallLen);
      if (k == resetAt) begin
        #2;
        rst = 1'b1;
        expRd.delete();
        expWr.delete();
        expDone.delete();
        expBusy.delete();
        #1;
        checkOutput("asyncResetOutputs",
                    {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                     wr_en, wr_addr_a, wr_addr_b}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 40 && expDone.size() != 0; i++) @(posedge clk);
    checkOutput("doneTimeout", expDone.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("readsLeft", expRd.size(), 0);
    checkOutput("writesLeft", expWr.size(), 0);
    checkOutput("idleBusy", busy, 0);
    if (resetAt == 0) checkOutput("writeCount", wrCount, 12);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int span, j, g, expA, expB, expTw;
    rst     = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    agStage = '0;
    agBfly  = '0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("resetOutputs",
                {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                 wr_en, wr_addr_a, wr_addr_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Address generator at N=16 against the div/mod reference formula.
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        agStage = 2'(s);
        agBfly  = 3'(b);
        #1;
        span  = 16 >> (s + 1);
        j     = b % span;
        g     = b / span;
        expA  = g * 2 * span + j;
        expB  = expA + span;
        expTw = (j << s) % 8;
        checkOutput($sformatf("agenA s%0d b%0d", s, b), agA, expA);
        checkOutput($sformatf("agenB s%0d b%0d", s, b), agB, expB);
        checkOutput($sformatf("agenTw s%0d b%0d", s, b), agTw, expTw);
      end
    end
    agStage = 2'd3;
    agBfly  = 3'd7;
    #1;
    checkOutput("agenS3B7", {agA, agB, agTw}, {4'd14, 4'd15, 3'd0});
    agStage = 2'd0;
    agBfly  = 3'd7;
    #1;
    checkOutput("agenS0B7", {agA, agB, agTw}, {4'd7, 4'd15, 3'd7});

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(8, 3, 0, 0, 0);
    applyStimulus(0, 0, 7, 16, 0);
    applyStimulus(0, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
